// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU pipeline and a single-port word-wide data memory.
// Handles byte/halfword/word accesses, sign/zero extension and read-modify-write for sub-word stores.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        misalign,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        wr_q;
  logic        sign_ext_q;
  logic [31:0] merged;

  function automatic logic is_rejected(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'b11) ||
           (sz == SZ_HALF && lo[0]) ||
           (sz == SZ_WORD && lo != 2'b00);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sx);
    logic [31:0]        shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    shifted = word >> {lane, 3'b000};
    b       = shifted[7:0];
    h       = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = {{24{sx & b[7]}}, b};
      SZ_HALF: r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = (word & ~(32'h0000_00FF << {lane, 3'b000})) |
                   ({24'b0, wd[7:0]} << {lane, 3'b000});
      SZ_HALF: r = lane[1] ? {wd[15:0], word[15:0]} : {word[31:16], wd[15:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      wr_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      merged     <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            size_q     <= size;
            wr_q       <= wr;
            sign_ext_q <= sign_ext;
            if (is_rejected(size, addr[1:0])) begin
              done     <= 1'b1;
              misalign <= 1'b1;
            end else if (wr && size == SZ_WORD) begin
              // Whole-word stores skip the read; merged simply carries the store data.
              merged <= wdata;
              state  <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (wr_q) begin
            merged <= store_merge(mem_rd, size_q, addr_q[1:0], wdata_q);
            state  <= WRITE;
          end else begin
            rdata <= load_extract(mem_rd, size_q, addr_q[1:0], sign_ext_q);
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        WRITE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write enable is gated by reset directly so a reset edge in WRITE never commits the store.
  assign busy   = (state != IDLE);
  assign mem_we = (state == WRITE) & ~reset;
  assign mem_a  = {addr_q[31:2], 2'b00};
  assign mem_wd = merged;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-addressed memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        misalign;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .busy     (busy),
    .misalign (misalign),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we)      mem[mem_a[7:2]] <= mem_wd;
    else if (pre_we) mem[pre_idx]    <= pre_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] data);
    pre_idx  = byte_addr[7:2];
    pre_data = data;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; size = sz; sign_ext = sx; addr = a; wdata = d;
  endtask

  // Issue a load, wait the fixed READ cycle, and check the result on the done cycle.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, sx, a, 32'h0);
    tick();
    req = 1'b0;
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check_eq({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    tick();
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
    check_eq({tag, "_rdata"}, rdata, exp);
    tick();
    check_eq({tag, "_done_once"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_misalign", {31'b0, misalign}, 32'd0);
    check_eq("rst_we", {31'b0, mem_we}, 32'd0);
    check_eq("rst_mem_a", mem_a, 32'h0);
    poke(32'd64, 32'h0);

    // sw 0x2D @64 then lw @64
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'd64, 32'h0000_002D);
    tick();
    req = 1'b0;
    check_eq("sw_busy", {31'b0, busy}, 32'd1);
    check_eq("sw_we", {31'b0, mem_we}, 32'd1);
    check_eq("sw_mem_a", mem_a, 32'd64);
    check_eq("sw_mem_wd", mem_wd, 32'h0000_002D);
    check_eq("sw_done_early", {31'b0, done}, 32'd0);
    tick();
    check_eq("sw_done", {31'b0, done}, 32'd1);
    check_eq("sw_we_off", {31'b0, mem_we}, 32'd0);
    check_eq("sw_mem", mem[16], 32'h0000_002D);
    tick();
    check_eq("sw_done_once", {31'b0, done}, 32'd0);
    do_load("lw64", 2'b10, 1'b0, 32'd64, 32'h0000_002D);

    // sb 0xAB @130 with read-modify-write
    poke(32'd128, 32'h1122_3344);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'd130, 32'h0000_00AB);
    tick();
    req = 1'b0;
    check_eq("sb_read_we", {31'b0, mem_we}, 32'd0);
    check_eq("sb_read_busy", {31'b0, busy}, 32'd1);
    tick();
    check_eq("sb_write_we", {31'b0, mem_we}, 32'd1);
    check_eq("sb_mem_wd", mem_wd, 32'h11AB_3344);
    check_eq("sb_done_early", {31'b0, done}, 32'd0);
    tick();
    check_eq("sb_done", {31'b0, done}, 32'd1);
    check_eq("sb_mem", mem[32], 32'h11AB_3344);
    check_eq("sb_rdata_hold", rdata, 32'h0000_002D);
    tick();

    // sub-word load extension
    poke(32'd128, 32'h80FF_7F01);
    do_load("lb129", 2'b00, 1'b1, 32'd129, 32'h0000_007F);
    do_load("lbu130", 2'b00, 1'b0, 32'd130, 32'h0000_00FF);
    do_load("lh130", 2'b01, 1'b1, 32'd130, 32'hFFFF_80FF);
    do_load("lhu128", 2'b01, 1'b0, 32'd128, 32'h0000_7F01);
    do_load("lb131", 2'b00, 1'b1, 32'd131, 32'hFFFF_FF80);

    // rejection lh @65, followed immediately by sw 0x55 @64
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'd65, 32'h0);
    tick();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'd64, 32'h0000_0055);
    check_eq("rej_done", {31'b0, done}, 32'd1);
    check_eq("rej_misalign", {31'b0, misalign}, 32'd1);
    check_eq("rej_busy", {31'b0, busy}, 32'd0);
    check_eq("rej_we", {31'b0, mem_we}, 32'd0);
    check_eq("rej_rdata", rdata, 32'hFFFF_FF80);
    tick();
    req = 1'b0;
    check_eq("rej_next_busy", {31'b0, busy}, 32'd1);
    check_eq("rej_next_we", {31'b0, mem_we}, 32'd1);
    check_eq("rej_pulse_done", {31'b0, done}, 32'd0);
    check_eq("rej_pulse_mis", {31'b0, misalign}, 32'd0);
    tick();
    check_eq("rej_sw_done", {31'b0, done}, 32'd1);
    check_eq("rej_sw_mem", mem[16], 32'h0000_0055);
    tick();

    // reserved size and misaligned word are both rejected
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'd64, 32'h0);
    tick();
    req = 1'b0;
    check_eq("rsv_misalign", {31'b0, misalign}, 32'd1);
    check_eq("rsv_busy", {31'b0, busy}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'd66, 32'hDEAD_BEEF);
    tick();
    req = 1'b0;
    check_eq("sw66_misalign", {31'b0, misalign}, 32'd1);
    check_eq("sw66_we", {31'b0, mem_we}, 32'd0);
    tick();
    check_eq("sw66_mem", mem[16], 32'h0000_0055);

    // sh @64 with reset asserted while in WRITE
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'd64, 32'h0000_1234);
    tick();
    req = 1'b0;
    tick();
    check_eq("rstw_we_before", {31'b0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rstw_we_gated", {31'b0, mem_we}, 32'd0);
    tick();
    reset = 1'b0;
    check_eq("rstw_done", {31'b0, done}, 32'd0);
    check_eq("rstw_busy", {31'b0, busy}, 32'd0);
    check_eq("rstw_rdata", rdata, 32'h0);
    check_eq("rstw_mem_a", mem_a, 32'h0);
    check_eq("rstw_mem_wd", mem_wd, 32'h0);
    check_eq("rstw_mem", mem[16], 32'h0000_0055);
    tick();
    check_eq("rstw_done_late", {31'b0, done}, 32'd0);

    // back-to-back: lw @64 then sw @128 with req held high
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'd64, 32'h0);
    tick();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'd128, 32'hCAFE_F00D);
    check_eq("b2b_rd_busy", {31'b0, busy}, 32'd1);
    tick();
    check_eq("b2b_lw_done", {31'b0, done}, 32'd1);
    check_eq("b2b_lw_rdata", rdata, 32'h0000_0055);
    check_eq("b2b_lw_busy", {31'b0, busy}, 32'd0);
    tick();
    check_eq("b2b_sw_busy", {31'b0, busy}, 32'd1);
    check_eq("b2b_sw_we", {31'b0, mem_we}, 32'd1);
    check_eq("b2b_sw_mem_a", mem_a, 32'd128);
    check_eq("b2b_sw_done_gap", {31'b0, done}, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'd64, 32'h0);
    tick();
    req = 1'b0;
    check_eq("b2b_sw_done", {31'b0, done}, 32'd1);
    check_eq("b2b_sw_mem", mem[32], 32'hCAFE_F00D);
    check_eq("b2b_rdata_hold", rdata, 32'h0000_0055);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
